md_alu_sequencer: RTL
=====================

// Module: md_alu_sequencer
// PURPOSE
//   Multi-cycle multiply/divide sequencer for the multi-cycle CPU. Executes MULT/MULTU/DIV/DIVU
//   by issuing a fixed sequence of add/sub operations to the shared 32-bit ALU through a
//   dedicated ALU port, and writes the 64-bit result to HI/LO. Sits beside the main controller,
//   which asserts start and stalls on busy. Shifts, counters and carry/borrow bits are internal.
// PARAMETERS
//   DW       32        datapath width; only 32 is supported
//   ITERS    32        shift/add or shift/sub iterations; must equal DW
// PORTS
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous, active-low reset
//   start      in   1   request; sampled only in IDLE
//   op         in   2   00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a          in   32  multiplicand / dividend (captured when start is accepted)
//   b          in   32  multiplier / divisor (captured when start is accepted)
//   busy       out  1   high from the cycle after acceptance through DONE
//   done       out  1   one-cycle pulse in DONE; hi/lo are valid from this cycle
//   hi, lo     out  32  product {hi,lo}; div: hi=remainder, lo=quotient; held until next accept
//   div_zero   out  1   set with done when a divide had b==0; cleared on next accept
//   alu_conf   out  5   ALU opcode: ADD 5'b00000, SUB 5'b00110; ADD when idle
//   alu_sign   out  1   always 0
//   alu_in1    out  32  ALU operand 1; 0 when idle
//   alu_in2    out  32  ALU operand 2; 0 when idle
//   alu_result in   32  combinational ALU result for the same cycle
// BEHAVIOUR
//   Reset: state=IDLE; busy=done=div_zero=0; hi=lo=0; counter=0. Mid-operation reset aborts.
//   States: IDLE -> ABS_A -> ABS_B -> ITER(x32) -> FIX_LO -> FIX_HI -> DONE -> IDLE.
//   Fixed latency for every op: start accepted at edge k; done high during cycle k+37.
//   start while busy or in DONE is ignored (no queueing); start in IDLE with reset low ignored.
//   ABS_A/ABS_B (signed op and operand negative): ALU SUB 0-x, store |x|; else ADD x+0 (pass).
//   Signed -2^31 magnitude = 32'h8000_0000 treated as unsigned; no trap.
//   MUL ITER: if lo[0], ALU ADD hi+|a|, carry = (sum < hi) internal; {c,hi,lo} >>= 1.
//   DIV ITER: rem33 = {rem,q[31]}; ge = rem33 >= |b| (internal 33-bit compare);
//     ALU SUB rem33[31:0]-|b| used when ge; shift quotient bit ge into lo.
//   Sign fix: MUL negate iff sign(a)^sign(b); DIV quotient negate iff signs differ,
//     remainder negate iff a negative. Only for signed ops.
//   FIX_LO: ALU SUB 0-lo (or pass via ADD lo+0). FIX_HI: ALU ADD ~hi + cin, where
//     cin = (lo_pre_fix==0) for MUL, 1 for DIV remainder; pass via ADD hi+0 otherwise.
//   b==0 on divide: full latency kept; hi=a (original), lo=32'hFFFF_FFFF, div_zero=1 in DONE.
//   DIV -2^31 / -1: lo=32'h8000_0000, hi=0, div_zero=0.
//   Counter: 6 bits, loads 0 in ABS_B, increments in ITER, leaves ITER at 31.
//   alu_conf/alu_in* are combinational from state and registers; result registered same edge.
// STRUCTURE
//   Shared header md_alu_defs.vh: ALU opcode constants (ADD/SUB), op encodings, state codes.
//   Single module; no sub-module (iteration counter and compares stay inline).
//   Bench instantiates the real ALU on the alu_* port.
// TESTING
//   MULTU a=32'hFFFF_FFFF b=32'hFFFF_FFFF -> hi=32'hFFFF_FFFE lo=32'h0000_0001, done at k+37
//   MULT a=-3 b=7 -> hi=32'hFFFF_FFFF lo=32'hFFFF_FFEB; MULT a=0 b=-5 -> hi=lo=0
//   DIV a=-7 b=2 -> lo=32'hFFFF_FFFD hi=32'hFFFF_FFFF; DIVU a=100 b=7 -> lo=14 hi=2
//   DIVU a=5 b=0 -> hi=5 lo=32'hFFFF_FFFF div_zero=1; DIV 32'h8000_0000 / -1 -> lo=32'h8000_0000 hi=0
//   start pulsed at cycles k+3, k+37 during op -> ignored; busy stays 1; one done only
//   reset low at ITER cycle 10 -> busy=done=0, hi=lo=0 immediately; next start completes normally

Source files
------------

// File: rtl/md_alu_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: ALU opcodes driven on
// the shared-ALU port, op encodings, FSM state codes and small op decoders.
package md_alu_sequencer_pkg;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00110;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ABS_A  = 3'd1,
    S_ABS_B  = 3'd2,
    S_ITER   = 3'd3,
    S_FIX_LO = 3'd4,
    S_FIX_HI = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  // Signed variants are MULT and DIV.
  function automatic logic op_is_signed(input logic [1:0] o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

  // Divide variants are everything that is not a multiply.
  function automatic logic op_is_div(input logic [1:0] o);
    return !((o == OP_MULTU) || (o == OP_MULT));
  endfunction

endpackage

// File: rtl/md_alu_sequencer.sv
// Multi-cycle multiply/divide sequencer. Runs MULT/MULTU/DIV/DIVU as a fixed
// sequence of add/sub operations on the shared 32-bit ALU and leaves the
// 64-bit result in hi/lo. Latency is identical for every op.
// Ports:
//   clk, reset (async, active-low)
//   start, op[1:0], a, b         request; sampled only in IDLE
//   busy, done, hi, lo, div_zero status and result (registered)
//   alu_conf, alu_sign, alu_in1, alu_in2 / alu_result   shared-ALU port
module md_alu_sequencer
  import md_alu_sequencer_pkg::*;
#(
  parameter int DW    = 32,
  parameter int ITERS = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo,
  output logic          div_zero,
  output logic [4:0]    alu_conf,
  output logic          alu_sign,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  input  logic [DW-1:0] alu_result
);

  localparam logic [5:0] LAST_ITER = 6'(ITERS - 1);

  state_e        state_q;
  logic [5:0]    cnt_q;
  logic [1:0]    op_q;
  logic [DW-1:0] a_q, b_q, mag_a_q, mag_b_q, hi_q, lo_q;
  logic          lo_zero_q, busy_q, done_q, div_zero_q;

  logic          signed_s, div_s, neg_a_s, neg_b_s, neg_lo_s, neg_hi_s;
  logic          ge_s, carry_s, cin_s;
  logic [DW:0]   rem33_s;
  logic [DW-1:0] hi_d, lo_d;

  assign signed_s = op_is_signed(op_q);
  assign div_s    = op_is_div(op_q);
  assign neg_a_s  = signed_s & a_q[DW-1];
  assign neg_b_s  = signed_s & b_q[DW-1];
  // Quotient/product sign is the xor; a remainder follows the dividend.
  assign neg_lo_s = neg_a_s ^ neg_b_s;
  assign neg_hi_s = div_s ? neg_a_s : (neg_a_s ^ neg_b_s);
  // Two's-complement of the upper word needs the borrow out of the lower word
  // for a 64-bit product; the remainder is negated on its own.
  assign cin_s    = div_s ? 1'b1 : lo_zero_q;

  assign rem33_s  = {hi_q, lo_q[DW-1]};
  assign ge_s     = (rem33_s >= {1'b0, mag_b_q});
  assign carry_s  = (alu_result < hi_q);

  // Shared-ALU operand/opcode selection for the current state.
  always_comb begin
    alu_conf = ALU_ADD;
    alu_in1  = {DW{1'b0}};
    alu_in2  = {DW{1'b0}};
    case (state_q)
      S_ABS_A: begin
        if (neg_a_s) begin alu_conf = ALU_SUB; alu_in2 = a_q; end
        else         begin alu_in1 = a_q; end
      end
      S_ABS_B: begin
        if (neg_b_s) begin alu_conf = ALU_SUB; alu_in2 = b_q; end
        else         begin alu_in1 = b_q; end
      end
      S_ITER: begin
        if (div_s) begin
          alu_conf = ALU_SUB;
          alu_in1  = rem33_s[DW-1:0];
          alu_in2  = mag_b_q;
        end else if (lo_q[0]) begin
          alu_in1 = hi_q;
          alu_in2 = mag_a_q;
        end else begin
          alu_in1 = hi_q;
        end
      end
      S_FIX_LO: begin
        if (neg_lo_s) begin alu_conf = ALU_SUB; alu_in2 = lo_q; end
        else          begin alu_in1 = lo_q; end
      end
      S_FIX_HI: begin
        if (neg_hi_s) begin alu_in1 = ~hi_q; alu_in2 = {{(DW-1){1'b0}}, cin_s}; end
        else          begin alu_in1 = hi_q; end
      end
      default: begin
        alu_conf = ALU_ADD;
      end
    endcase
  end

  // One iteration step: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_s) begin
      hi_d = ge_s ? alu_result : rem33_s[DW-1:0];
      lo_d = {lo_q[DW-2:0], ge_s};
    end else if (lo_q[0]) begin
      hi_d = {carry_s, alu_result[DW-1:1]};
      lo_d = {alu_result[0], lo_q[DW-1:1]};
    end else begin
      hi_d = {1'b0, hi_q[DW-1:1]};
      lo_d = {hi_q[0], lo_q[DW-1:1]};
    end
  end

  // Sequencer FSM with registered status and result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 6'd0;
      op_q       <= 2'b00;
      a_q        <= {DW{1'b0}};
      b_q        <= {DW{1'b0}};
      mag_a_q    <= {DW{1'b0}};
      mag_b_q    <= {DW{1'b0}};
      hi_q       <= {DW{1'b0}};
      lo_q       <= {DW{1'b0}};
      lo_zero_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_ABS_A;
            busy_q     <= 1'b1;
            op_q       <= op;
            a_q        <= a;
            b_q        <= b;
            hi_q       <= {DW{1'b0}};
            lo_q       <= {DW{1'b0}};
            div_zero_q <= 1'b0;
          end
        end
        S_ABS_A: begin
          mag_a_q <= alu_result;
          // The dividend magnitude is shifted out of lo into the remainder.
          if (div_s) lo_q <= alu_result;
          state_q <= S_ABS_B;
        end
        S_ABS_B: begin
          mag_b_q <= alu_result;
          // The multiplier magnitude is consumed from lo bit 0.
          if (!div_s) lo_q <= alu_result;
          hi_q    <= {DW{1'b0}};
          cnt_q   <= 6'd0;
          state_q <= S_ITER;
        end
        S_ITER: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == LAST_ITER) state_q <= S_FIX_LO;
        end
        S_FIX_LO: begin
          lo_q      <= alu_result;
          lo_zero_q <= (lo_q == {DW{1'b0}});
          state_q   <= S_FIX_HI;
        end
        S_FIX_HI: begin
          // Divide by zero reports the original dividend and an all-ones quotient.
          if (div_s && (b_q == {DW{1'b0}})) begin
            hi_q       <= a_q;
            lo_q       <= {DW{1'b1}};
            div_zero_q <= 1'b1;
          end else begin
            hi_q <= alu_result;
          end
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;
  assign alu_sign = 1'b0;

endmodule
